// File: rtl/fsm_1.sv
// Two-state Moore FSM (A/B, one-hot) with asynchronous active-high reset.
// Define FSM_1_SAFE_STATE_EN to add recovery from illegal state encodings back to B.
module fsm_1 #(
    parameter int RESET_STATE = 1
) (
    input  logic in,
    input  logic clk,
    input  logic areset,
    output logic out
);

    typedef enum logic [1:0] {
        ST_A = 2'b01,
        ST_B = 2'b10
    } state_t;

    localparam logic [1:0] RST_ENC = (RESET_STATE != 0) ? ST_B : ST_A;

    logic [1:0] r_state;
    logic [1:0] w_next;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state <= RST_ENC;
        end else begin
            r_state <= w_next;
        end
    end

    // An unknown input falls through to the hold branch, leaving the state unchanged.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_A: begin
                case (in)
                    1'b0:    w_next = ST_B;
                    1'b1:    w_next = ST_A;
                    default: w_next = r_state;
                endcase
            end
            ST_B: begin
                case (in)
                    1'b0:    w_next = ST_A;
                    1'b1:    w_next = ST_B;
                    default: w_next = r_state;
                endcase
            end
            default: begin
`ifdef FSM_1_SAFE_STATE_EN
                w_next = ST_B;
`else
                w_next = r_state;
`endif
            end
        endcase
    end

    always_comb begin
`ifdef FSM_1_SAFE_STATE_EN
        out = (r_state != ST_A);
`else
        out = r_state[1];
`endif
    end

endmodule

// File: tb/tb_fsm_1.sv
// Self-checking bench for fsm_1: directed scenarios plus randomized input/reset traffic
// compared against a behavioural "output toggles on in=0" model.
module tb_fsm_1;

    logic in;
    logic clk;
    logic areset;
    logic out;

    int n_checks;
    int n_fail;
    bit m_out;

    fsm_1 #(.RESET_STATE(1)) dut (
        .in     (in),
        .clk    (clk),
        .areset (areset),
        .out    (out)
    );

    // One full clock period; returns 1 ns after the rising edge so outputs are settled.
    task automatic step(input bit v);
        #4 clk = 1'b0;
        in = v;
        #5 clk = 1'b1;
        if (!areset && v == 1'b0) m_out = ~m_out;
        #1;
    endtask

    task automatic test_reset();
        clk = 1'b0;
        in = 1'b1;
        areset = 1'b1;
        m_out = 1'b1;
        #1;
        n_checks++;
        if (out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_immediate: out=%b expected=1", out);
        end
        n_checks++;
        if (dut.r_state !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_encoding: state=%b expected=10", dut.r_state);
        end
        #19;
        n_checks++;
        if (out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold_20ns: out=%b expected=1", out);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0);
            n_checks++;
            if (out !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_ignores_edge%0d: out=%b expected=1", i, out);
            end
        end
        #2 areset = 1'b0;
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            n_checks++;
            if (out !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_edge%0d: out=%b expected=1", i, out);
            end
        end
    endtask

    task automatic test_toggle();
        bit exp_seq [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            n_checks++;
            if (out !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL toggle_edge%0d: out=%b expected=%b", i, out, exp_seq[i]);
            end
        end
    endtask

    task automatic test_mixed();
        bit in_seq  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        bit exp_seq [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            step(in_seq[i]);
            n_checks++;
            if (out !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL mixed_edge%0d: out=%b expected=%b", i, out, exp_seq[i]);
            end
        end
    endtask

    // Entered with the FSM in A (the mixed sequence ends with out = 0).
    task automatic test_midrun_reset();
        n_checks++;
        if (out !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_pre_state_A: out=%b expected=0", out);
        end
        #1 areset = 1'b1;
        m_out = 1'b1;
        #1;
        n_checks++;
        if (out !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_reset_immediate: out=%b expected=1", out);
        end
        #4 areset = 1'b0;
        step(1'b1);
        n_checks++;
        if (out !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_after_edge: out=%b expected=1", out);
        end
        step(1'b0);
        n_checks++;
        if (out !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_first_transition: out=%b expected=0", out);
        end
    endtask

    task automatic test_random();
        bit v;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                #1 areset = 1'b1;
                m_out = 1'b1;
                #1;
                n_checks++;
                if (out !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rand_reset_%0d: out=%b expected=1", i, out);
                end
                #1 areset = 1'b0;
            end
            v = 1'($urandom_range(0, 1));
            step(v);
            n_checks++;
            if (out !== m_out) begin
                n_fail++;
                $display("FAIL rand_edge%0d in=%b: out=%b expected=%b", i, v, out, m_out);
            end
            n_checks++;
            if (dut.r_state !== {m_out, ~m_out}) begin
                n_fail++;
                $display("FAIL rand_state%0d: state=%b expected=%b", i, dut.r_state, {m_out, ~m_out});
            end
        end
    endtask

`ifdef FSM_1_SAFE_STATE_EN
    task automatic test_recovery();
        #1 force dut.r_state = 2'b11;
        #1 release dut.r_state;
        #1;
        n_checks++;
        if (out !== 1'b1) begin
            n_fail++;
            $display("FAIL recovery_out: out=%b expected=1", out);
        end
        step(1'b1);
        m_out = 1'b1;
        n_checks++;
        if (dut.r_state !== 2'b10) begin
            n_fail++;
            $display("FAIL recovery_state: state=%b expected=10", dut.r_state);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_hold();
        test_toggle();
        step(1'b1);
        test_mixed();
        test_midrun_reset();
        test_random();
`ifdef FSM_1_SAFE_STATE_EN
        test_recovery();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
